uart_tx_fifo: RTL

Serial UART transmitter (8 data bits, 1 start, 1 stop, LSB first, idle-high line) with a small input FIFO so the bus-side master can queue bytes without waiting for each frame. It sits between the bus slave register interface and the board TX pin, and pairs with our UART receiver for loopback and host links. Bit timing uses the same `CLKS_PER_BIT` convention as the receiver: `CLKS_PER_BIT = f(i_Clock) / baud`.

---
 rtl/uart_tx_fifo_if.sv | 10 +
 rtl/uart_tx_fifo.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-queue handshake between the bus-side master and the UART transmitter.
interface uart_tx_fifo_if;
    logic       i_Tx_DV;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Ready;
    logic [4:0] o_Fifo_Count;

    modport master (output i_Tx_DV, i_Tx_Byte, input o_Tx_Ready, o_Fifo_Count);
    modport slave  (input i_Tx_DV, i_Tx_Byte, output o_Tx_Ready, o_Fifo_Count);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular FIFO, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           i_Clock,
    input  logic           i_Rst_n,
    uart_tx_fifo_if.slave  bus,
    output logic           o_Tx_Serial,
    output logic           o_Tx_Active,
    output logic           o_Tx_Done
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] CLEANUP = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY  = 3'd5;
`endif

    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]  count;
    logic [7:0]   mem_q [FIFO_DEPTH];
    logic         full, empty, wr_en, pop;

    logic [2:0]   state_q, state_d;
    logic [15:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]   bit_idx_q, bit_idx_d;
    logic [7:0]   shift_q, shift_d;
    logic         serial_q, serial_d;
    logic         active_q, active_d;
    logic         done_q, done_d;
    logic         bit_end;

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_en   = bus.i_Tx_DV && !full;
    assign pop     = (state_q == IDLE) && !empty;
    assign count   = wr_ptr_q - rd_ptr_q;
    assign bit_end = (clk_cnt_q == CNT_MAX);

    assign wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    assign bus.o_Tx_Ready   = !full;
    assign bus.o_Fifo_Count = 5'(count);
    assign o_Tx_Serial      = serial_q;
    assign o_Tx_Active      = active_q;
    assign o_Tx_Done        = done_q;

    always_ff @(posedge i_Clock) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= bus.i_Tx_Byte;
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + 16'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        active_d  = active_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                serial_d  = 1'b1;
                active_d  = 1'b0;
                clk_cnt_d = '0;
                if (!empty) begin
                    shift_d   = mem_q[rd_ptr_q[AW-1:0]];
                    bit_idx_d = '0;
                    serial_d  = 1'b0;
                    active_d  = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    serial_d = shift_q[0];
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        serial_d = ^shift_q;
                        state_d  = PARITY;
`else
                        serial_d = 1'b1;
                        state_d  = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        serial_d  = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    serial_d = 1'b1;
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = CLEANUP;
                end
            end
            CLEANUP: begin
                serial_d  = 1'b1;
                clk_cnt_d = '0;
                state_d   = IDLE;
            end
            default: begin
                serial_d  = 1'b1;
                active_d  = 1'b0;
                clk_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end
endmodule
